// File: rtl/network_rx_interface_if.sv
// Beat-stream input, message handshake and status bundle
// for the network receive framer.
interface network_rx_interface_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   rx_data;
  logic          rx_valid;
  logic          rx_sof;
  logic          rx_eof;
  logic [127:0]  msg_data;
  logic          msg_valid;
  logic          msg_ready;
  logic [CW-1:0] fifo_count;
  logic [15:0]   rx_drop_count;

  modport master (
    output rx_data, rx_valid, rx_sof, rx_eof,
    output msg_ready,
    input  msg_data, msg_valid,
    input  fifo_count, rx_drop_count
  );

  modport slave (
    input  rx_data, rx_valid, rx_sof, rx_eof,
    input  msg_ready,
    output msg_data, msg_valid,
    output fifo_count, rx_drop_count
  );
endinterface

// File: rtl/network_rx_interface.sv
// Frames 32-bit network beats into 128-bit messages,
// drops malformed/overflowing frames, buffers in a FWFT FIFO.
module network_rx_interface #(
  parameter int DEPTH = 4
) (
  input logic                   i_core_clk,
  input logic                   i_reset,
  network_rx_interface_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    ASSEMBLE,
    DISCARD
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [1:0]     r_cnt;
  logic [1:0]     w_cnt_nxt;
  logic [31:0]    r_word [3];
  logic           w_store;
  logic [1:0]     w_store_idx;
  logic           w_push_req;
  logic           w_err;

  logic [127:0]   r_mem [DEPTH];
  logic [AW-1:0]  r_rd_ptr;
  logic [AW-1:0]  r_wr_ptr;
  logic [CW-1:0]  r_count;
  logic [15:0]    r_drop_cnt;

  logic           w_pop;
  logic           w_push;
  logic           w_drop;
  logic [127:0]   w_msg;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_store     = 1'b0;
    w_store_idx = r_cnt;
    w_push_req  = 1'b0;
    w_err       = 1'b0;
    if (bus.rx_valid) begin
      unique case (r_state)
        IDLE, DISCARD: begin
          if (bus.rx_sof && !bus.rx_eof) begin
            w_store     = 1'b1;
            w_store_idx = 2'd0;
            w_cnt_nxt   = 2'd1;
            w_state_nxt = ASSEMBLE;
          end else if (bus.rx_sof) begin
            w_err       = 1'b1;
            w_cnt_nxt   = 2'd0;
            w_state_nxt = IDLE;
          end else if (bus.rx_eof) begin
            w_cnt_nxt   = 2'd0;
            w_state_nxt = IDLE;
          end
        end
        ASSEMBLE: begin
          // a one-beat sof&eof here is both a restart and malformed
          if (bus.rx_sof && bus.rx_eof) begin
            w_err       = 1'b1;
            w_cnt_nxt   = 2'd0;
            w_state_nxt = IDLE;
          end else if (bus.rx_sof) begin
            w_err       = 1'b1;
            w_store     = 1'b1;
            w_store_idx = 2'd0;
            w_cnt_nxt   = 2'd1;
          end else if (bus.rx_eof) begin
            w_push_req  = (r_cnt == 2'd3);
            w_err       = (r_cnt != 2'd3);
            w_cnt_nxt   = 2'd0;
            w_state_nxt = IDLE;
          end else if (r_cnt == 2'd3) begin
            w_err       = 1'b1;
            w_cnt_nxt   = 2'd0;
            w_state_nxt = DISCARD;
          end else begin
            w_store     = 1'b1;
            w_cnt_nxt   = r_cnt + 2'd1;
          end
        end
        default: begin
          w_cnt_nxt   = 2'd0;
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign w_pop  = (r_count != '0) && bus.msg_ready;
  assign w_push = w_push_req &&
                  ((r_count < CW'(DEPTH)) || w_pop);
  assign w_drop = w_err || (w_push_req && !w_push);
  assign w_msg  = {r_word[0], r_word[1], r_word[2], bus.rx_data};

  always_ff @(posedge i_core_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      for (int i = 0; i < 3; i++) r_word[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_store) r_word[w_store_idx] <= bus.rx_data;
    end
  end

  always_ff @(posedge i_core_clk) begin
    if (i_reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_msg;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge i_core_clk) begin
    if (i_reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign bus.msg_data      = r_mem[r_rd_ptr];
  assign bus.msg_valid     = (r_count != '0);
  assign bus.fifo_count    = r_count;
  assign bus.rx_drop_count = r_drop_cnt;
endmodule

// File: tb/tb_network_rx_interface.sv
// Directed self-checking bench for network_rx_interface.
// Inputs change 1ns after posedge; deliveries logged at negedge.
module tb_network_rx_interface;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic [127:0] got [$];

  network_rx_interface_if #(.DEPTH(4)) bus ();

  network_rx_interface #(.DEPTH(4)) dut (
    .i_core_clk (clk),
    .i_reset    (rst),
    .bus        (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && bus.msg_valid && bus.msg_ready)
      got.push_back(bus.msg_data);

  function automatic logic [127:0] frame_of(input logic [31:0] b);
    return {b, b + 32'd1, b + 32'd2, b + 32'd3};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic beat(input logic [31:0] d,
                      input logic s, input logic e);
    bus.rx_data  = d;
    bus.rx_sof   = s;
    bus.rx_eof   = e;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    bus.rx_sof   = 1'b0;
    bus.rx_eof   = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] b);
    beat(b, 1'b1, 1'b0);
    beat(b + 32'd1, 1'b0, 1'b0);
    beat(b + 32'd2, 1'b0, 1'b0);
    beat(b + 32'd3, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.rx_valid  = 1'b0;
    bus.msg_ready = 1'b0;
    idle(2);
    rst = 1'b0;
    got.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (bus.msg_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_valid got %b want 0", bus.msg_valid);
    end
    n_cmp++;
    if (bus.fifo_count !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_count got %0d want 0", bus.fifo_count);
    end
    n_cmp++;
    if (bus.rx_drop_count !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_drop got %h want 0", bus.rx_drop_count);
    end
    n_cmp++;
    if (bus.msg_data !== 128'd0) begin
      n_bad++;
      $display("FAIL reset_data got %h want 0", bus.msg_data);
    end
  endtask

  task automatic test_single_frame();
    logic [127:0] exp;
    do_reset();
    exp = 128'h11111111_22222222_33333333_44444444;
    bus.msg_ready = 1'b1;
    beat(32'h11111111, 1'b1, 1'b0);
    beat(32'h22222222, 1'b0, 1'b0);
    beat(32'h33333333, 1'b0, 1'b0);
    n_cmp++;
    if (bus.msg_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_early got %b want 0", bus.msg_valid);
    end
    beat(32'h44444444, 1'b0, 1'b1);
    n_cmp++;
    if (bus.msg_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL single_valid got %b want 1", bus.msg_valid);
    end
    n_cmp++;
    if (bus.msg_data !== exp) begin
      n_bad++;
      $display("FAIL single_data got %h want %h", bus.msg_data, exp);
    end
    tick();
    n_cmp++;
    if (bus.msg_valid !== 1'b0 || bus.fifo_count !== 3'd0) begin
      n_bad++;
      $display("FAIL single_drain got v=%b c=%0d want v=0 c=0",
               bus.msg_valid, bus.fifo_count);
    end
    n_cmp++;
    if (bus.rx_drop_count !== 16'd0) begin
      n_bad++;
      $display("FAIL single_drop got %0d want 0", bus.rx_drop_count);
    end
  endtask

  task automatic test_malformed();
    logic [31:0] b [4];
    b = '{32'h10000000, 32'h20000000, 32'h30000000, 32'h40000000};
    do_reset();
    bus.msg_ready = 1'b1;
    beat(32'hA0000000, 1'b1, 1'b0);
    beat(32'hA0000001, 1'b0, 1'b0);
    beat(32'hA0000002, 1'b0, 1'b1);
    n_cmp++;
    if (bus.rx_drop_count !== 16'd1) begin
      n_bad++;
      $display("FAIL short_drop got %0d want 1", bus.rx_drop_count);
    end
    send_frame(b[0]);
    for (int i = 0; i < 5; i++)
      beat(32'hB0000000 + i, (i == 0), (i == 4));
    n_cmp++;
    if (bus.rx_drop_count !== 16'd2) begin
      n_bad++;
      $display("FAIL long_drop got %0d want 2", bus.rx_drop_count);
    end
    send_frame(b[1]);
    beat(32'hC0000000, 1'b1, 1'b0);
    beat(32'hC0000001, 1'b0, 1'b0);
    send_frame(b[2]);
    beat(32'hD0000000, 1'b1, 1'b1);
    send_frame(b[3]);
    idle(3);
    n_cmp++;
    if (bus.rx_drop_count !== 16'd4) begin
      n_bad++;
      $display("FAIL malformed_drop got %0d want 4", bus.rx_drop_count);
    end
    n_cmp++;
    if (got.size() != 4) begin
      n_bad++;
      $display("FAIL malformed_n got %0d want 4", got.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= got.size() || got[i] !== frame_of(b[i])) begin
        n_bad++;
        $display("FAIL malformed_msg%0d got %h want %h",
                 i, (i < got.size()) ? got[i] : 128'hx, frame_of(b[i]));
      end
    end
  endtask

  task automatic test_back_to_back_overflow();
    logic [31:0] b [6];
    for (int i = 0; i < 6; i++) b[i] = 32'h01000000 * (i + 1);
    do_reset();
    for (int i = 0; i < 6; i++) send_frame(b[i]);
    n_cmp++;
    if (bus.fifo_count !== 3'd4) begin
      n_bad++;
      $display("FAIL ovf_count got %0d want 4", bus.fifo_count);
    end
    n_cmp++;
    if (bus.rx_drop_count !== 16'd2) begin
      n_bad++;
      $display("FAIL ovf_drop got %0d want 2", bus.rx_drop_count);
    end
    bus.msg_ready = 1'b1;
    idle(6);
    n_cmp++;
    if (got.size() != 4 || bus.msg_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_drain got n=%0d v=%b want n=4 v=0",
               got.size(), bus.msg_valid);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= got.size() || got[i] !== frame_of(b[i])) begin
        n_bad++;
        $display("FAIL ovf_msg%0d got %h want %h",
                 i, (i < got.size()) ? got[i] : 128'hx, frame_of(b[i]));
      end
    end
  endtask

  task automatic test_full_pop();
    logic [31:0] b [5];
    for (int i = 0; i < 5; i++) b[i] = 32'h00500000 + 32'h100 * i;
    do_reset();
    for (int i = 0; i < 4; i++) send_frame(b[i]);
    n_cmp++;
    if (bus.fifo_count !== 3'd4) begin
      n_bad++;
      $display("FAIL full_count got %0d want 4", bus.fifo_count);
    end
    beat(b[4], 1'b1, 1'b0);
    beat(b[4] + 32'd1, 1'b0, 1'b0);
    beat(b[4] + 32'd2, 1'b0, 1'b0);
    bus.msg_ready = 1'b1;
    beat(b[4] + 32'd3, 1'b0, 1'b1);
    bus.msg_ready = 1'b0;
    n_cmp++;
    if (bus.fifo_count !== 3'd4 || bus.rx_drop_count !== 16'd0) begin
      n_bad++;
      $display("FAIL fullpop got c=%0d d=%0d want c=4 d=0",
               bus.fifo_count, bus.rx_drop_count);
    end
    n_cmp++;
    if (bus.msg_data !== frame_of(b[1])) begin
      n_bad++;
      $display("FAIL fullpop_head got %h want %h",
               bus.msg_data, frame_of(b[1]));
    end
    bus.msg_ready = 1'b1;
    idle(6);
    n_cmp++;
    if (got.size() != 5) begin
      n_bad++;
      $display("FAIL fullpop_n got %0d want 5", got.size());
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (i >= got.size() || got[i] !== frame_of(b[i])) begin
        n_bad++;
        $display("FAIL fullpop_msg%0d got %h want %h",
                 i, (i < got.size()) ? got[i] : 128'hx, frame_of(b[i]));
      end
    end
  endtask

  task automatic test_stall_gaps();
    logic [127:0] exp;
    exp = 128'h0A0A0A0A_0B0B0B0B_0C0C0C0C_0D0D0D0D;
    do_reset();
    bus.msg_ready = 1'b1;
    beat(32'hDEAD0001, 1'b0, 1'b0);
    beat(32'hDEAD0002, 1'b0, 1'b1);
    idle(1);
    beat(32'h0A0A0A0A, 1'b1, 1'b0);
    idle(2);
    beat(32'h0B0B0B0B, 1'b0, 1'b0);
    idle(1);
    beat(32'h0C0C0C0C, 1'b0, 1'b0);
    idle(3);
    beat(32'h0D0D0D0D, 1'b0, 1'b1);
    idle(2);
    n_cmp++;
    if (got.size() != 1 || (got.size() == 1 && got[0] !== exp)) begin
      n_bad++;
      $display("FAIL stall_msg got n=%0d m=%h want n=1 m=%h",
               got.size(), (got.size() > 0) ? got[0] : 128'hx, exp);
    end
    n_cmp++;
    if (bus.rx_drop_count !== 16'd0) begin
      n_bad++;
      $display("FAIL stall_drop got %0d want 0", bus.rx_drop_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    beat(32'hEE000000, 1'b1, 1'b1);
    send_frame(32'h61000000);
    send_frame(32'h62000000);
    beat(32'h63000000, 1'b1, 1'b0);
    beat(32'h63000001, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    n_cmp++;
    if (bus.msg_valid !== 1'b0 || bus.fifo_count !== 3'd0 ||
        bus.rx_drop_count !== 16'd0 || bus.msg_data !== 128'd0) begin
      n_bad++;
      $display("FAIL midreset got v=%b c=%0d d=%0d m=%h want all 0",
               bus.msg_valid, bus.fifo_count,
               bus.rx_drop_count, bus.msg_data);
    end
    rst = 1'b0;
    got.delete();
    bus.msg_ready = 1'b1;
    send_frame(32'h64000000);
    idle(2);
    n_cmp++;
    if (got.size() != 1 ||
        (got.size() == 1 && got[0] !== frame_of(32'h64000000))) begin
      n_bad++;
      $display("FAIL postreset got n=%0d m=%h want n=1 m=%h",
               got.size(), (got.size() > 0) ? got[0] : 128'hx,
               frame_of(32'h64000000));
    end
    n_cmp++;
    if (bus.rx_drop_count !== 16'd0) begin
      n_bad++;
      $display("FAIL postreset_drop got %0d want 0", bus.rx_drop_count);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    force dut.r_drop_cnt = 16'hFFFE;
    #1;
    release dut.r_drop_cnt;
    for (int i = 0; i < 3; i++) begin
      beat(32'h5A5A0000 + i, 1'b1, 1'b1);
      n_cmp++;
      if (bus.rx_drop_count !== 16'hFFFF) begin
        n_bad++;
        $display("FAIL sat_drop%0d got %h want FFFF",
                 i, bus.rx_drop_count);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.rx_data   = '0;
    bus.rx_valid  = 1'b0;
    bus.rx_sof    = 1'b0;
    bus.rx_eof    = 1'b0;
    bus.msg_ready = 1'b0;
    tick();
    test_reset();
    test_single_frame();
    test_malformed();
    test_back_to_back_overflow();
    test_full_pop();
    test_stall_gaps();
    test_reset_mid_frame();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/network_rx_interface.md
# network_rx_interface

Receive-side counterpart of the order transmit path: accepts the 32-bit beat stream from the network receiver and frames it into 128-bit messages (exchange acks, fills, market data). Malformed or overflowing frames are dropped and counted, never passed on. Good messages are buffered in a small first-word-fall-through FIFO and handed to the core with a valid/ready handshake. The network side cannot be back-pressured, so this block absorbs bursts and discards on overflow.

## Interface
- DEPTH, 4, message FIFO depth in 128-bit entries; power of two, ≥2
- core_clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- rx_data  in  32  network beat payload
- rx_valid  in  1  beat qualifier; beats with rx_valid=0 are ignored entirely
- rx_sof  in  1  first beat of a frame (qualified by rx_valid)
- rx_eof  in  1  last beat of a frame (qualified by rx_valid)
- msg_data  out  128  head-of-FIFO message; word0 in [127:96], word3 in [31:0]
- msg_valid  out  1  FIFO non-empty
- msg_ready  in  1  core accepts head; pop when msg_valid & msg_ready
- fifo_count  out  $clog2(DEPTH+1)  entries currently held
- rx_drop_count  out  16  frames dropped; saturates at 16'hFFFF

## Operation
- Valid frame: exactly 4 beats, rx_sof on beat 0 only, rx_eof on beat 3 only.
- Framer FSM, states IDLE, ASSEMBLE, DISCARD; beat index cnt (2 bits).
- IDLE: sof&!eof → store beat as word0, cnt=1, go ASSEMBLE. sof&eof → drop (+1), stay IDLE. Beat without sof → ignored, not counted.
- ASSEMBLE, on each valid beat:
  - sof → drop partial frame (+1), store this beat as word0, cnt=1, stay ASSEMBLE.
  - eof & cnt==3 → frame complete, push {w0,w1,w2,beat}, go IDLE.
  - eof & cnt<3 → short frame, drop (+1), go IDLE.
  - !eof & cnt==3 → long frame, drop (+1), go DISCARD.
  - else → store word[cnt], cnt++.
- DISCARD: sof&!eof → start new frame as in IDLE. sof&eof → +1, go IDLE (counted as a new malformed frame). eof alone → go IDLE. Other beats ignored.
- Push: accepted if fifo_count<DEPTH, or if a pop occurs in the same cycle. Otherwise the complete frame is dropped (+1).
- Multiple drop causes in one cycle add at most +1 per cycle. Counter saturates and never wraps.
- FIFO: circular buffer with rd/wr pointers of log2(DEPTH) bits that wrap naturally. fifo_count is tracked separately. Simultaneous push and pop leaves the count unchanged.
- msg_data = mem[rd_ptr]; value is don't-care while msg_valid=0.
- Reset: state IDLE, cnt=0, pointers 0, fifo_count=0, msg_valid=0, msg_data=0 (mem cleared), rx_drop_count=0. Reset mid-frame discards the partial frame and all buffered messages without counting them.

## Timing
- FSM, FIFO and counters are all registered on core_clk.
- Latency: eof beat at edge N → msg_valid=1 and msg_data valid after edge N (visible in cycle N+1) when the FIFO was empty.
- Back-to-back frames are supported: a new sof is accepted on the cycle immediately after an eof.
- Sustained throughput is 1 beat/cycle, i.e. one message every 4 cycles.
- Pop at edge M → next entry, or msg_valid=0, visible in cycle M+1. msg_valid never depends combinationally on msg_ready.
- rx_drop_count updates at the edge that detects the error.

## Test plan
- Single frame: beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 (sof on the first, eof on the last), msg_ready=1 → msg_valid high for 1 cycle, starting one cycle after the eof beat. msg_data=0x11111111_22222222_33333333_44444444. fifo_count returns to 0. rx_drop_count=0.
- Malformed frames, each followed by a good frame: short (eof on beat 2), long (5 beats), sof at beat 2, sof&eof on one beat → rx_drop_count=4. Only the good frames are delivered, intact and in order.
- Overflow: msg_ready=0, 6 back-to-back good frames with DEPTH=4 → fifo_count=4, rx_drop_count=2. Then msg_ready=1 → first 4 frames delivered in order, then msg_valid=0.
- Full with simultaneous pop: FIFO holds 4 entries, a frame's eof coincides with a pop cycle → frame accepted, fifo_count stays 4, no drop.
- Stall and idle gaps: rx_valid=0 gaps between beats, and stray non-sof beats in IDLE → frame assembled correctly, no drop counted.
- Reset mid-frame after 2 beats with 2 entries buffered → all outputs at reset values next cycle. A following good frame is delivered normally. Drop-counter saturation is preloaded via force to 16'hFFFE, then 3 drops → counter stays 16'hFFFF.
